// File: rtl/ex_mem_reg_pkg.sv
// ex_mem_reg_pkg: shared widths, enables and stall bit positions for the
// EX/MEM pipeline register, plus the stall-vector decode helper.
package ex_mem_reg_pkg;

  // Bus widths
  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;
  localparam int RegAddrBus   = 5;
  localparam int CntBus       = 2;
  localparam int StallBus     = 6;

  // Reset and write-enable levels
  localparam logic RstEnable    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  // Zero constants
  localparam logic [RegBus-1:0]       ZeroWord       = 32'h0000_0000;
  localparam logic [DoubleRegBus-1:0] ZeroDoubleWord = 64'h0000_0000_0000_0000;
  localparam logic [RegAddrBus-1:0]   ZeroRegAddr    = 5'h00;
  localparam logic [CntBus-1:0]       ZeroCnt        = 2'b00;

  // Stall vector bit positions
  localparam int StallEx  = 3;
  localparam int StallMem = 4;

  // Per-cycle behaviour of the EX/MEM stage
  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_BUBBLE = 2'b01,
    MODE_HOLD   = 2'b10
  } stage_mode_e;

  // Only the execute and memory hold bits matter. Memory held while execute
  // runs cannot happen in a well-formed pipeline; it is treated as HOLD so
  // nothing is lost or duplicated.
  function automatic stage_mode_e decode_mode(input logic [StallBus-1:0] stall);
    stage_mode_e mode;
    case ({stall[StallMem], stall[StallEx]})
      2'b00:   mode = MODE_PASS;
      2'b01:   mode = MODE_BUBBLE;
      2'b11:   mode = MODE_HOLD;
      2'b10:   mode = MODE_HOLD;
      default: mode = MODE_HOLD;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register. Passes execute results to the memory
// stage, inserts a NOP bubble when execute is held alone, and freezes when
// memory is held. Optional macro EX_MEM_MADD_EN adds the partial-product /
// cycle-count feedback registers used by multi-cycle multiply-accumulate;
// without it hilo_o and cnt_o are constant zero.
module ex_mem_reg
  import ex_mem_reg_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic [RegAddrBus-1:0]   ex_wd,
  input  logic                    ex_wreg,
  input  logic [RegBus-1:0]       ex_wdata,
  input  logic                    ex_whilo,
  input  logic [RegBus-1:0]       ex_hi,
  input  logic [RegBus-1:0]       ex_lo,
  input  logic [DoubleRegBus-1:0] hilo_i,
  input  logic [CntBus-1:0]       cnt_i,
  output logic [RegAddrBus-1:0]   mem_wd,
  output logic                    mem_wreg,
  output logic [RegBus-1:0]       mem_wdata,
  output logic                    mem_whilo,
  output logic [RegBus-1:0]       mem_hi,
  output logic [RegBus-1:0]       mem_lo,
  output logic [DoubleRegBus-1:0] hilo_o,
  output logic [CntBus-1:0]       cnt_o
);

  stage_mode_e w_mode;

  logic [RegAddrBus-1:0] r_wd;
  logic                  r_wreg;
  logic [RegBus-1:0]     r_wdata;
  logic                  r_whilo;
  logic [RegBus-1:0]     r_hi;
  logic [RegBus-1:0]     r_lo;

  assign w_mode = decode_mode(stall);

  // Memory-stage payload: load, bubble to NOP, or hold; reset wins over all.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_wd    <= ZeroRegAddr;
      r_wreg  <= WriteDisable;
      r_wdata <= ZeroWord;
      r_whilo <= WriteDisable;
      r_hi    <= ZeroWord;
      r_lo    <= ZeroWord;
    end else begin
      case (w_mode)
        MODE_PASS: begin
          r_wd    <= ex_wd;
          r_wreg  <= ex_wreg;
          r_wdata <= ex_wdata;
          r_whilo <= ex_whilo;
          r_hi    <= ex_hi;
          r_lo    <= ex_lo;
        end
        MODE_BUBBLE: begin
          r_wd    <= ZeroRegAddr;
          r_wreg  <= WriteDisable;
          r_wdata <= ZeroWord;
          r_whilo <= WriteDisable;
          r_hi    <= ZeroWord;
          r_lo    <= ZeroWord;
        end
        MODE_HOLD: begin
          r_wd    <= r_wd;
          r_wreg  <= r_wreg;
          r_wdata <= r_wdata;
          r_whilo <= r_whilo;
          r_hi    <= r_hi;
          r_lo    <= r_lo;
        end
        default: begin
          r_wd    <= r_wd;
          r_wreg  <= r_wreg;
          r_wdata <= r_wdata;
          r_whilo <= r_whilo;
          r_hi    <= r_hi;
          r_lo    <= r_lo;
        end
      endcase
    end
  end

  assign mem_wd    = r_wd;
  assign mem_wreg  = r_wreg;
  assign mem_wdata = r_wdata;
  assign mem_whilo = r_whilo;
  assign mem_hi    = r_hi;
  assign mem_lo    = r_lo;

`ifdef EX_MEM_MADD_EN
  logic [DoubleRegBus-1:0] r_hilo;
  logic [CntBus-1:0]       r_cnt;

  // Accumulate feedback: kept while execute iterates (bubble), cleared once
  // the instruction leaves execute (pass), frozen on hold. cnt is stored raw.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_hilo <= ZeroDoubleWord;
      r_cnt  <= ZeroCnt;
    end else begin
      case (w_mode)
        MODE_PASS: begin
          r_hilo <= ZeroDoubleWord;
          r_cnt  <= ZeroCnt;
        end
        MODE_BUBBLE: begin
          r_hilo <= hilo_i;
          r_cnt  <= cnt_i;
        end
        MODE_HOLD: begin
          r_hilo <= r_hilo;
          r_cnt  <= r_cnt;
        end
        default: begin
          r_hilo <= r_hilo;
          r_cnt  <= r_cnt;
        end
      endcase
    end
  end

  assign hilo_o = r_hilo;
  assign cnt_o  = r_cnt;
`else
  // Feature absent: feedback inputs are deliberately dropped.
  logic w_unused_madd;
  assign w_unused_madd = ^{hilo_i, cnt_i};

  assign hilo_o = ZeroDoubleWord;
  assign cnt_o  = ZeroCnt;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: directed vectors with hand-computed expectations pushed into
// a scoreboard queue; a separate monitor pops one entry per clock and compares.
module tb_ex_mem_reg;

`ifdef EX_MEM_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  typedef struct packed {
    logic        rst;
    logic [5:0]  stall;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } vec_t;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = 6'h00;
  logic [4:0]  ex_wd = 5'h00;
  logic        ex_wreg = 1'b0;
  logic [31:0] ex_wdata = 32'h0;
  logic        ex_whilo = 1'b0;
  logic [31:0] ex_hi = 32'h0;
  logic [31:0] ex_lo = 32'h0;
  logic [63:0] hilo_i = 64'h0;
  logic [1:0]  cnt_i = 2'b00;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  exp_t exp_q[$];
  int   vec_ids[$];
  int   n_vectors = 0;
  int   n_miscompares = 0;
  int   vec_no = 0;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  // Feedback outputs are only live when the accumulate feature is built in.
  function automatic logic [63:0] mh(input logic [63:0] x);
    return MADD ? x : 64'h0;
  endfunction

  function automatic logic [1:0] mc(input logic [1:0] x);
    return MADD ? x : 2'b00;
  endfunction

  task automatic check_field(input string name, input int id,
                             input logic [63:0] got, input logic [63:0] want);
    if (got !== want) begin
      n_miscompares++;
      $display("FAIL %s vec %0d: got %h expected %h", name, id, got, want);
    end
  endtask

  // Drive one vector away from the active edge and queue its expectation.
  task automatic apply(input vec_t v, input exp_t e);
    @(negedge clk);
    rst      = v.rst;
    stall    = v.stall;
    ex_wd    = v.wd;
    ex_wreg  = v.wreg;
    ex_wdata = v.wdata;
    ex_whilo = v.whilo;
    ex_hi    = v.hi;
    ex_lo    = v.lo;
    hilo_i   = v.hilo;
    cnt_i    = v.cnt;
    vec_no++;
    exp_q.push_back(e);
    vec_ids.push_back(vec_no);
    @(posedge clk);
  endtask

  // Monitor: one registered result per edge, checked just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      int   id;
      e  = exp_q.pop_front();
      id = vec_ids.pop_front();
      n_vectors++;
      check_field("mem_wd",    id, {59'h0, mem_wd},    {59'h0, e.wd});
      check_field("mem_wreg",  id, {63'h0, mem_wreg},  {63'h0, e.wreg});
      check_field("mem_wdata", id, {32'h0, mem_wdata}, {32'h0, e.wdata});
      check_field("mem_whilo", id, {63'h0, mem_whilo}, {63'h0, e.whilo});
      check_field("mem_hi",    id, {32'h0, mem_hi},    {32'h0, e.hi});
      check_field("mem_lo",    id, {32'h0, mem_lo},    {32'h0, e.lo});
      check_field("hilo_o",    id, hilo_o,             e.hilo);
      check_field("cnt_o",     id, {62'h0, cnt_o},     {62'h0, e.cnt});
    end
  end

  initial begin
    vec_t v;
    exp_t e;
    exp_t held;
    int   waited;

    // 1: reset with every input nonzero and stall all ones -> all zero
    v = '{1'b1, 6'h3F, 5'h1F, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          64'hFFFF_FFFF_FFFF_FFFF, 2'b11};
    e = '{5'h00, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h0, 2'b00};
    apply(v, e);

    // 2: PASS loads mem_*, feedback cleared even with nonzero hilo_i
    v = '{1'b0, 6'h00, 5'd8, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0,
          64'h0000_0000_0000_5555, 2'b10};
    e = '{5'd8, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 64'h0, 2'b00};
    apply(v, e);

    // 3: BUBBLE -> NOP, feedback captured
    v = '{1'b0, 6'b001000, 5'd3, 1'b1, 32'h0000_0099, 1'b1, 32'h11, 32'h22,
          64'hDEAD_BEEF_0000_0001, 2'b01};
    e = '{5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, mh(64'hDEAD_BEEF_0000_0001), mc(2'b01)};
    apply(v, e);

    // 4: PASS loads A5A5_A5A5
    v = '{1'b0, 6'h00, 5'd4, 1'b1, 32'hA5A5_A5A5, 1'b0, 32'h0, 32'h0, 64'h0, 2'b00};
    held = '{5'd4, 1'b1, 32'hA5A5_A5A5, 1'b0, 32'h0, 32'h0, 64'h0, 2'b00};
    apply(v, held);

    // 5-7: HOLD for three cycles while execute inputs change
    for (int k = 1; k <= 3; k++) begin
      v = '{1'b0, 6'b011000, 5'(k), 1'b0, 32'(k), 1'b1, 32'(k), 32'(k),
            64'(k), 2'(k)};
      apply(v, held);
    end

    // 8: BUBBLE storing cnt 2'b11 as-is
    v = '{1'b0, 6'b001000, 5'd9, 1'b1, 32'h9, 1'b0, 32'h0, 32'h0,
          64'h0123_4567_89AB_CDEF, 2'b11};
    held = '{5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, mh(64'h0123_4567_89AB_CDEF), mc(2'b11)};
    apply(v, held);

    // 9: illegal stall (memory held, execute free) behaves as HOLD
    v = '{1'b0, 6'b010000, 5'd7, 1'b1, 32'h7777_7777, 1'b1, 32'h7, 32'h7,
          64'h7, 2'b01};
    apply(v, held);

    // 10: only unrelated stall bits set -> PASS
    v = '{1'b0, 6'b100111, 5'h1F, 1'b0, 32'hCAFE_F00D, 1'b1, 32'h0000_AAAA, 32'h0000_BBBB,
          64'h55, 2'b10};
    e = '{5'h1F, 1'b0, 32'hCAFE_F00D, 1'b1, 32'h0000_AAAA, 32'h0000_BBBB, 64'h0, 2'b00};
    apply(v, e);

    // 11-12: two-cycle madd: BUBBLE with cnt 1, then PASS with HI/LO write
    v = '{1'b0, 6'b001000, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h10, 2'b01};
    e = '{5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, mh(64'h10), mc(2'b01)};
    apply(v, e);
    v = '{1'b0, 6'h00, 5'd0, 1'b0, 32'h0, 1'b1, 32'h1, 32'h2, 64'h10, 2'b10};
    e = '{5'd0, 1'b0, 32'h0, 1'b1, 32'h1, 32'h2, 64'h0, 2'b00};
    apply(v, e);

    // 13-14: accumulate in progress then held
    v = '{1'b0, 6'b001000, 5'd2, 1'b1, 32'h2, 1'b0, 32'h0, 32'h0, 64'h77, 2'b10};
    held = '{5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, mh(64'h77), mc(2'b10)};
    apply(v, held);
    v = '{1'b0, 6'b011000, 5'd6, 1'b1, 32'h6, 1'b1, 32'h6, 32'h6, 64'h66, 2'b11};
    apply(v, held);

    // 15: reset during HOLD abandons the accumulate
    v = '{1'b1, 6'b011000, 5'd6, 1'b1, 32'h6, 1'b1, 32'h6, 32'h6, 64'h66, 2'b11};
    e = '{5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h0, 2'b00};
    apply(v, e);

    // 16: first edge after reset is a normal PASS
    v = '{1'b0, 6'h00, 5'd5, 1'b1, 32'h0000_005A, 1'b1, 32'h3, 32'h4, 64'h99, 2'b01};
    held = '{5'd5, 1'b1, 32'h0000_005A, 1'b1, 32'h3, 32'h4, 64'h0, 2'b00};
    apply(v, held);

    // 17: all stall bits set -> HOLD
    v = '{1'b0, 6'h3F, 5'd1, 1'b0, 32'h1, 1'b0, 32'h1, 32'h1, 64'h1, 2'b01};
    apply(v, held);

    // Drain the scoreboard within a bounded number of cycles
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL provide port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL provide port rst, input, 1, synchronous active-high reset (sampled on clk rising edge only).
REQ-003 SHALL provide port stall, input, 6, pipeline stall vector; bit 3 = execute stage held, bit 4 = memory stage held.
REQ-004 SHALL provide inputs ex_wd (5), ex_wreg (1), ex_wdata (32): destination address, write enable and result from execute.
REQ-005 SHALL provide inputs ex_whilo (1), ex_hi (32), ex_lo (32): HI/LO write request and values from execute.
REQ-006 SHALL provide inputs hilo_i (64), cnt_i (2): partial multiply-accumulate product and cycle count from execute.
REQ-007 SHALL provide outputs mem_wd (5), mem_wreg (1), mem_wdata (32), mem_whilo (1), mem_hi (32), mem_lo (32): registered copies to memory stage.
REQ-008 SHALL provide outputs hilo_o (64), cnt_o (2): registered partial product and count returned to execute.
REQ-009 SHALL register every output; no combinational path from any input to any output.

Function
REQ-010 Three modes per cycle, chosen from stall[3] and stall[4]: PASS, BUBBLE, HOLD.
REQ-011 PASS (stall[3]=0): all mem_* outputs SHALL load the matching ex_* inputs on the next edge; latency exactly one cycle.
REQ-012 BUBBLE (stall[3]=1, stall[4]=0): mem_wd=0, mem_wreg=0, mem_wdata=0, mem_whilo=0, mem_hi=0, mem_lo=0 on the next edge (NOP into memory).
REQ-013 HOLD (stall[3]=1, stall[4]=1): every output SHALL keep its current value.
REQ-014 stall[3]=0 with stall[4]=1 is illegal; block SHALL treat it as HOLD.
REQ-015 In BUBBLE, hilo_o SHALL load hilo_i and cnt_o SHALL load cnt_i (partial result preserved while execute iterates).
REQ-016 In PASS, hilo_o SHALL clear to 64'h0 and cnt_o to 2'b00.
REQ-017 In HOLD, hilo_o and cnt_o SHALL hold.
REQ-018 cnt_i is passed unmodified; no arithmetic or wrap performed here; value 2'b11 stored as-is.
REQ-019 stall bits other than 3 and 4 SHALL be ignored.

Reset
REQ-020 With rst=1 at an edge, every output SHALL become zero (mem_wd=5'h0, mem_wreg=0, mem_wdata, mem_hi, mem_lo=32'h0, mem_whilo=0, hilo_o=64'h0, cnt_o=2'b00) regardless of stall.
REQ-021 Reset SHALL take priority over HOLD; a multi-cycle accumulate in progress is abandoned.
REQ-022 First edge after rst deasserts SHALL obey REQ-010..REQ-017 normally.

Configuration
REQ-023 Macro EX_MEM_MADD_EN: defined -> hilo_o/cnt_o registers and REQ-015..REQ-017 present.
REQ-024 EX_MEM_MADD_EN undefined -> hilo_i, cnt_i ignored; hilo_o tied 64'h0, cnt_o tied 2'b00; no storage for them; mem_* behaviour unchanged.

Structure
REQ-025 Widths (RegBus 32, DoubleRegBus 64, RegAddrBus 5), RstEnable, WriteEnable/WriteDisable, ZeroWord and stall bit indices SHALL come from the shared define file.
REQ-026 No sub-module; single flat register stage.

Verification
REQ-027 rst=1 with all inputs nonzero, stall=6'h3F -> all outputs zero after edge.
REQ-028 stall=0, ex_wd=5'd8, ex_wreg=1, ex_wdata=32'h1234_5678 -> same values on mem_* one edge later; hilo_o=0, cnt_o=0.
REQ-029 stall=6'b001000, ex_wreg=1, hilo_i=64'hDEAD_BEEF_0000_0001, cnt_i=2'b01 -> mem_wreg=0, mem_wdata=0, hilo_o=64'hDEAD_BEEF_0000_0001, cnt_o=2'b01 (macro defined; hilo_o=0 when undefined).
REQ-030 Load mem_wdata=32'hA5A5_A5A5, then stall=6'b011000 for 3 cycles with ex_wdata changing -> mem_wdata stays 32'hA5A5_A5A5.
REQ-031 Two-cycle madd: BUBBLE cycle with cnt_i=1, then PASS cycle with ex_whilo=1, ex_hi=32'h1, ex_lo=32'h2 -> mem_whilo=1, mem_hi=1, mem_lo=2, hilo_o and cnt_o cleared.
REQ-032 HOLD in progress, rst asserted for one cycle -> outputs zero next edge, then PASS resumes.
